// File: rtl/ram_responder_pkg.sv
// ram_responder_pkg: shared FSM state encoding for the RAM-side bus responder
package ram_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} state_t;
endpackage

// File: rtl/ram_responder_array.sv
// ram_responder_array: single-port storage, synchronous write and asynchronous read
module ram_responder_array #(
    parameter int d_width = 8,
    parameter int a_width = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [a_width-1:0] addr,
    input  logic [d_width-1:0] wdata,
    output logic [d_width-1:0] rdata
);
    logic [d_width-1:0] mem [2**a_width];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/ram_responder.sv
// ram_responder: fixed-latency memory responder driving the shared cache<->RAM data bus on reads
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int d_width = 8,
    parameter int a_width = 8,
    parameter int lat     = 3,
    parameter int hold    = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [a_width-1:0] addr_in,
    inout  wire  [d_width-1:0] data_io,
    input  logic               rw_in,
    input  logic               ce_in,
    output logic               rdy,
    output logic               busy
);
    localparam logic [3:0] lat_m1  = 4'(lat - 1);
    localparam logic [3:0] hold_m1 = 4'(hold - 1);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic rdy_q, rdy_d, busy_q, busy_d, drive_q, drive_d, rw_q, rw_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic [d_width-1:0] data_q, data_d, dout_q, dout_d, rd_data;
    logic accept, we;
    ram_responder_array #(.d_width(d_width), .a_width(a_width)) u_array (
        .clk(clk), .we(we), .addr(addr_d), .wdata(data_d), .rdata(rd_data)
    );
    // With lat==1 the strobe edge is also the RESP-entry edge, so live inputs feed the array directly.
    always_comb begin
        accept  = state_q == IDLE && ce_in;
        rw_d    = accept ? rw_in : rw_q;
        addr_d  = accept ? addr_in : addr_q;
        data_d  = accept ? data_io : data_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: if (ce_in) begin
                cnt_d   = lat_m1;
                busy_d  = 1'b1;
                state_d = lat == 1 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = cnt_q == 4'd1 ? RESP : WAIT;
            end
            RESP: if (rw_q && hold > 1) begin
                cnt_d   = hold_m1;
                state_d = HOLD;
            end else begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            HOLD: begin
                cnt_d   = cnt_q - 4'd1;
                busy_d  = cnt_q != 4'd1;
                state_d = cnt_q == 4'd1 ? IDLE : HOLD;
            end
        endcase
        rdy_d   = state_d == RESP;
        drive_d = (state_d == RESP && rw_d) || state_d == HOLD;
        dout_d  = state_d == RESP ? rd_data : dout_q;
        we      = state_d == RESP && !rw_d && !clr;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            drive_q <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            drive_q <= drive_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
        end
    end
    for (genvar i = 0; i < d_width; i++) begin : g_bus
        bufif1 b (data_io[i], dout_q[i], drive_q);
    end
    assign rdy  = rdy_q;
    assign busy = busy_q;
endmodule
